// File: rtl/sdrm_pkg.sv
// rtl/sdrm_pkg.sv - command encodings, FSM states and default timing for the SDRAM init/refresh sequencer
package sdrm_pkg;

    localparam logic [2:0] CMD_NOP = 3'b111;
    localparam logic [2:0] CMD_PRE = 3'b010;
    localparam logic [2:0] CMD_REF = 3'b001;
    localparam logic [2:0] CMD_MRS = 3'b000;

    localparam int          DEF_PWRUP_CYC    = 20000;
    localparam int          DEF_TRP_CYC      = 2;
    localparam int          DEF_TRFC_CYC     = 7;
    localparam int          DEF_TMRD_CYC     = 2;
    localparam int          DEF_INIT_REF_NUM = 8;
    localparam int          DEF_REF_INT      = 1560;
    localparam logic [10:0] DEF_MODE_REG     = 11'h032;

    typedef enum logic [3:0] {
        PWRUP, I_PRE, I_TRP, I_REF, I_TRFC, I_MRS, I_TMRD,
        IDLE, R_PRE, R_TRP, R_REF, R_TRFC
    } sdrm_state_t;

    function automatic logic [2:0] sdrm_state_cmd(input sdrm_state_t s);
        case (s)
            I_PRE, R_PRE: return CMD_PRE;
            I_REF, R_REF: return CMD_REF;
            I_MRS:        return CMD_MRS;
            default:      return CMD_NOP;
        endcase
    endfunction

endpackage

// File: rtl/sdrm_ref_timer.sv
// rtl/sdrm_ref_timer.sv - refresh interval counter and pending-refresh count (limit set by SDRM_REF_BACKLOG_EN)
module sdrm_ref_timer
    import sdrm_pkg::*;
#(
    parameter int REF_INT = DEF_REF_INT
)(
    input  logic       Clk_i,
    input  logic       Reset,
    input  logic       i_clear,
    input  logic       i_run,
    input  logic       i_dec,
    output logic [3:0] o_pending
);

`ifdef SDRM_REF_BACKLOG_EN
    localparam logic [3:0] PEND_MAX = 4'd8;
`else
    localparam logic [3:0] PEND_MAX = 4'd1;
`endif
    localparam int TW = (REF_INT > 1) ? $clog2(REF_INT) : 1;

    logic [TW-1:0] r_tick;
    logic [3:0]    r_pending;
    logic          w_wrap;

    assign w_wrap    = i_run && (r_tick == TW'(REF_INT - 1));
    assign o_pending = r_pending;

    always_ff @(posedge Clk_i) begin
        if (Reset || i_clear) begin
            r_tick <= '0;
        end else if (i_run) begin
            r_tick <= w_wrap ? '0 : r_tick + 1'b1;
        end
    end

    // A wrap coinciding with a serviced refresh cancels out, even when saturated.
    always_ff @(posedge Clk_i) begin
        if (Reset) begin
            r_pending <= '0;
        end else if (w_wrap && !i_dec) begin
            if (r_pending != PEND_MAX) r_pending <= r_pending + 1'b1;
        end else if (i_dec && !w_wrap) begin
            if (r_pending != 4'd0) r_pending <= r_pending - 1'b1;
        end
    end

endmodule

// File: rtl/sdrm_init_ref.sv
// rtl/sdrm_init_ref.sv - SDRAM power-up init sequencer and auto-refresh scheduler (burst refresh with SDRM_REF_BACKLOG_EN)
module sdrm_init_ref
    import sdrm_pkg::*;
#(
    parameter int          PWRUP_CYC    = DEF_PWRUP_CYC,
    parameter int          TRP_CYC      = DEF_TRP_CYC,
    parameter int          TRFC_CYC     = DEF_TRFC_CYC,
    parameter int          TMRD_CYC     = DEF_TMRD_CYC,
    parameter int          INIT_REF_NUM = DEF_INIT_REF_NUM,
    parameter int          REF_INT      = DEF_REF_INT,
    parameter logic [10:0] MODE_REG     = DEF_MODE_REG
)(
    input  logic        Clk_i,
    input  logic        Reset,
    input  logic        Locked_i,
    input  logic        ref_gnt,
    output logic        init_done,
    output logic        ref_req,
    output logic        ref_done,
    output logic        cmd_own,
    output logic        sd_ras_o,
    output logic        sd_cas_o,
    output logic        sd_we_o,
    output logic [10:0] sd_add_o,
    output logic        sd_ba_o
);

`ifdef SDRM_REF_BACKLOG_EN
    localparam bit BACKLOG = 1'b1;
`else
    localparam bit BACKLOG = 1'b0;
`endif
    localparam int CNT_W  = $clog2(PWRUP_CYC + TRP_CYC + TRFC_CYC + TMRD_CYC + 1);
    localparam int RCNT_W = $clog2(INIT_REF_NUM + 1);

    sdrm_state_t       r_state, w_next;
    logic [CNT_W-1:0]  r_cnt, w_lim;
    logic [RCNT_W-1:0] r_iref;
    logic [2:0]        r_cmd;
    logic [10:0]       r_add;
    logic              r_own, r_init_done, r_ref_done;
    logic              w_cnt_done;
    logic [3:0]        w_pending;

    // Wait states last (spacing - 1) cycles, so the counter ends at spacing - 2.
    always_comb begin
        w_lim = '0;
        case (r_state)
            PWRUP:          w_lim = CNT_W'(PWRUP_CYC - 1);
            I_TRP, R_TRP:   w_lim = CNT_W'(TRP_CYC - 2);
            I_TRFC, R_TRFC: w_lim = CNT_W'(TRFC_CYC - 2);
            I_TMRD:         w_lim = CNT_W'(TMRD_CYC - 2);
            default:        w_lim = '0;
        endcase
    end

    assign w_cnt_done = (r_cnt == w_lim);

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            PWRUP:  if (Locked_i && w_cnt_done) w_next = I_PRE;
            I_PRE:  w_next = I_TRP;
            I_TRP:  if (w_cnt_done) w_next = I_REF;
            I_REF:  w_next = I_TRFC;
            I_TRFC: if (w_cnt_done) w_next = (r_iref < RCNT_W'(INIT_REF_NUM)) ? I_REF : I_MRS;
            I_MRS:  w_next = I_TMRD;
            I_TMRD: if (w_cnt_done) w_next = IDLE;
            IDLE:   if (ref_gnt && ref_req) w_next = R_PRE;
            R_PRE:  w_next = R_TRP;
            R_TRP:  if (w_cnt_done) w_next = R_REF;
            R_REF:  w_next = R_TRFC;
            R_TRFC: if (w_cnt_done) w_next = (BACKLOG && ref_req) ? R_REF : IDLE;
            default: w_next = PWRUP;
        endcase
    end

    // Outputs decode the next state so they line up with the state they describe.
    always_ff @(posedge Clk_i) begin
        if (Reset) begin
            r_state     <= PWRUP;
            r_cmd       <= CMD_NOP;
            r_add       <= '0;
            r_own       <= 1'b0;
            r_init_done <= 1'b0;
            r_ref_done  <= 1'b0;
            r_cnt       <= '0;
            r_iref      <= '0;
        end else begin
            r_state    <= w_next;
            r_cmd      <= sdrm_state_cmd(w_next);
            r_add      <= (w_next == I_PRE || w_next == R_PRE) ? 11'h400 :
                          (w_next == I_MRS) ? MODE_REG : 11'h000;
            r_own      <= !(w_next == PWRUP || w_next == IDLE);
            r_ref_done <= (r_state == R_TRFC) && (w_next == IDLE);
            if (w_next == IDLE) r_init_done <= 1'b1;
            if (w_next != r_state || r_state == IDLE || (r_state == PWRUP && !Locked_i))
                r_cnt <= '0;
            else
                r_cnt <= r_cnt + 1'b1;
            if (r_state == I_REF) r_iref <= r_iref + 1'b1;
        end
    end

    sdrm_ref_timer #(
        .REF_INT (REF_INT)
    ) u_ref_timer (
        .Clk_i     (Clk_i),
        .Reset     (Reset),
        .i_clear   ((r_state == I_TMRD) && (w_next == IDLE)),
        .i_run     (r_init_done),
        .i_dec     (r_state == R_REF),
        .o_pending (w_pending)
    );

    assign {sd_ras_o, sd_cas_o, sd_we_o} = r_cmd;
    assign sd_add_o  = r_add;
    assign sd_ba_o   = 1'b0;
    assign cmd_own   = r_own;
    assign init_done = r_init_done;
    assign ref_done  = r_ref_done;
    assign ref_req   = (w_pending != 4'd0);

endmodule

// File: tb/tb_sdrm_init_ref.sv
// tb/tb_sdrm_init_ref.sv - randomized bench for sdrm_init_ref against a timeline model (SDRM_REF_BACKLOG_EN aware)
module tb_sdrm_init_ref;

    localparam int PW = 10, TRP = 2, TRFC = 7, TMRD = 2, NREF = 2, RINT = 50;
    localparam logic [10:0] MREG = 11'h032;
`ifdef SDRM_REF_BACKLOG_EN
    localparam int SAT = 8;
    localparam bit BACKLOG = 1'b1;
`else
    localparam int SAT = 1;
    localparam bit BACKLOG = 1'b0;
`endif
    localparam logic [2:0] NOP = 3'b111, PRE = 3'b010, REF = 3'b001, MRS = 3'b000;
    localparam int PH_PW = 0, PH_INIT = 1, PH_OP = 2;

    logic        clk = 1'b0;
    logic        rst, lock, gnt;
    logic        init_done, ref_req, ref_done, cmd_own;
    logic        ras, cas, we, ba;
    logic [10:0] add;

    always #5 clk = ~clk;

    sdrm_init_ref #(
        .PWRUP_CYC (PW), .TRP_CYC (TRP), .TRFC_CYC (TRFC), .TMRD_CYC (TMRD),
        .INIT_REF_NUM (NREF), .REF_INT (RINT), .MODE_REG (MREG)
    ) dut (
        .Clk_i (clk), .Reset (rst), .Locked_i (lock), .ref_gnt (gnt),
        .init_done (init_done), .ref_req (ref_req), .ref_done (ref_done), .cmd_own (cmd_own),
        .sd_ras_o (ras), .sd_cas_o (cas), .sd_we_o (we), .sd_add_o (add), .sd_ba_o (ba)
    );

    int checks = 0, errors = 0;
    int k = 0;
    int phase = PH_PW, lock_run = 0, t0 = 0, pend = 0, next_wrap = 0;
    int pre_at = -1000, last_ref = -1000;
    bit done = 0, ref_active = 0;
    logic [2:0]  e_cmd = NOP;
    logic [10:0] e_add = '0;
    bit e_own = 0, e_rdone = 0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got 0x%0h expected 0x%0h", tag, k, act, exp);
        end
    endtask

    // Predicts the outputs of cycle k from the inputs sampled at the edge that starts it.
    task automatic model_edge(input bit r, input bit l, input bit g);
        int  pend_prev, o, mrs_at;
        bit  inc, dec;
        pend_prev = pend;
        e_cmd = NOP; e_add = '0; e_own = 0; e_rdone = 0;
        k++;
        if (r) begin
            phase = PH_PW; lock_run = 0; done = 0; pend = 0; ref_active = 0;
            pre_at = -1000; last_ref = -1000;
            return;
        end
        if (phase == PH_PW) begin
            lock_run = l ? lock_run + 1 : 0;
            if (lock_run == PW) begin
                phase = PH_INIT;
                t0 = k;
            end
        end
        if (phase == PH_INIT) begin
            o = k - t0;
            mrs_at = TRP + NREF * TRFC;
            if (o == mrs_at + TMRD) begin
                phase = PH_OP; done = 1; next_wrap = k + RINT;
            end else begin
                e_own = 1;
                if (o == 0) begin e_cmd = PRE; e_add = 11'h400; end
                else if (o == mrs_at) begin e_cmd = MRS; e_add = MREG; end
                else if (o >= TRP && o < mrs_at && (o - TRP) % TRFC == 0) e_cmd = REF;
            end
        end else if (phase == PH_OP) begin
            dec = (last_ref == k - 1);
            if (!ref_active) begin
                if (g && pend_prev != 0) begin
                    ref_active = 1; pre_at = k;
                    e_cmd = PRE; e_add = 11'h400; e_own = 1;
                end
            end else if (k == pre_at + TRP) begin
                e_cmd = REF; e_own = 1; last_ref = k;
            end else if (last_ref > pre_at && k == last_ref + TRFC) begin
                if (BACKLOG && pend_prev != 0) begin
                    e_cmd = REF; e_own = 1; last_ref = k;
                end else begin
                    ref_active = 0; e_rdone = 1;
                end
            end else begin
                e_own = 1;
            end
            inc = (k == next_wrap);
            if (inc) next_wrap += RINT;
            if (inc && !dec) pend = (pend < SAT) ? pend + 1 : pend;
            else if (dec && !inc) pend = pend - 1;
        end
    endtask

    task automatic compare_outputs();
        check("cmd",       {29'd0, ras, cas, we}, {29'd0, e_cmd});
        check("add",       {21'd0, add},          {21'd0, e_add});
        check("ba",        {31'd0, ba},           32'd0);
        check("cmd_own",   {31'd0, cmd_own},      {31'd0, e_own});
        check("init_done", {31'd0, init_done},    {31'd0, done});
        check("ref_req",   {31'd0, ref_req},      {31'd0, (pend != 0)});
        check("ref_done",  {31'd0, ref_done},     {31'd0, e_rdone});
    endtask

    task automatic step(input bit r, input bit l, input bit g);
        @(negedge clk);
        rst = r; lock = l; gnt = g;
        @(posedge clk);
        model_edge(r, l, g);
        #1;
        compare_outputs();
    endtask

    task automatic run_to_init();
        for (int i = 0; i < 200 && !done; i++) step(0, 1, 0);
        check("init_reached", {31'd0, init_done}, 32'd1);
    endtask

    task automatic wait_pending();
        for (int i = 0; i < 200 && pend == 0; i++) step(0, 1, 0);
        check("req_reached", {31'd0, ref_req}, 32'd1);
    endtask

    initial begin
        bit r, l, g;
        rst = 1'b1; lock = 1'b0; gnt = 1'b0;

        repeat (3) step(1, 1, 0);
        run_to_init();
        repeat (20) step(0, 1, 1);
        wait_pending();
        step(0, 1, 1);
        repeat (15) step(0, 1, 0);

        step(1, 1, 0);
        repeat (5) step(0, 1, 0);
        step(0, 0, 0);
        run_to_init();

        step(1, 1, 0);
        run_to_init();
        repeat (119) step(0, 1, 0);
        step(0, 1, 1);
        repeat (30) step(0, 1, 0);

        wait_pending();
        step(0, 1, 1);
        repeat (5) step(0, 1, 0);
        step(1, 1, 0);
        run_to_init();

        for (int i = 0; i < 3000; i++) begin
            r = ($urandom_range(0, 999) == 0);
            l = ($urandom_range(0, 7) != 0);
            g = ((i % 400) < 200) ? 1'b0 : ($urandom_range(0, 3) == 0);
            step(r, l, g);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
